// File: rtl/inst_loop_sequencer.sv
// inst_loop_sequencer
//   Program-counter sequencer for the instruction memory. Walks PC from 0 and
//   applies up to three nested hardware loops (loop 0 innermost). One PC is
//   issued per valid/ready handshake; busy/done are reported to the CSR core.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, clr_i        start pulse (IDLE only), synchronous clear
//   cfg_loop_mode_i       0 = linear, 1..3 = number of active nested loops
//   cfg_jump_addr_i[k]    loop k start address
//   cfg_end_addr_i[k]     loop k end address
//   cfg_loop_count_i[k]   loop k body executions (0 behaves as 1)
//   inst_pc_o/valid_o     PC to the datapath, inst_ready_i accepts it
//   busy_o, done_o        high in RUN / one-cycle completion pulse
//
// Optional build: INST_LOOP_SEQ_STEP_EN adds dbg_step_mode_i and dbg_step_i.
//   In step mode a PC is only offered while a step token is held; the token
//   is set by a dbg_step_i pulse and consumed by the handshake.
module inst_loop_sequencer #(
    parameter int InstAddrWidth  = 8,
    parameter int LoopCountWidth = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                clr_i,
    input  logic [1:0]                          cfg_loop_mode_i,
    input  logic [2:0][InstAddrWidth-1:0]       cfg_jump_addr_i,
    input  logic [2:0][InstAddrWidth-1:0]       cfg_end_addr_i,
    input  logic [2:0][LoopCountWidth-1:0]      cfg_loop_count_i,
`ifdef INST_LOOP_SEQ_STEP_EN
    input  logic                                dbg_step_mode_i,
    input  logic                                dbg_step_i,
`endif
    output logic [InstAddrWidth-1:0]            inst_pc_o,
    output logic                                inst_valid_o,
    input  logic                                inst_ready_i,
    output logic                                busy_o,
    output logic                                done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                              state_q, state_d;
    logic [InstAddrWidth-1:0]            pc_q, pc_d;
    logic [2:0][LoopCountWidth-1:0]      cnt_q, cnt_d;
    logic [1:0]                          mode_q, mode_d;
    logic [2:0][InstAddrWidth-1:0]       jump_q, jump_d;
    logic [2:0][InstAddrWidth-1:0]       end_q, end_d;
    logic [2:0][LoopCountWidth-1:0]      count_q, count_d;

    // Loop-chain results, applied only when the current PC fires
    logic [InstAddrWidth-1:0]            pc_nxt;
    logic [2:0][LoopCountWidth-1:0]      cnt_nxt;
    logic [LoopCountWidth-1:0]           lim;
    logic [InstAddrWidth-1:0]            last_end;
    logic                                redirect;
    logic                                final_pc;
    logic                                fire;
    logic                                gate;

`ifdef INST_LOOP_SEQ_STEP_EN
    logic tok_q, tok_d;
    assign gate = !dbg_step_mode_i || tok_q;
`else
    assign gate = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        jump_d   = jump_q;
        end_d    = end_q;
        count_d  = count_q;
        pc_nxt   = pc_q + 1'b1;
        cnt_nxt  = cnt_q;
        lim      = '0;
        redirect = 1'b0;

        inst_valid_o = (state_q == S_RUN) && gate;
        busy_o       = (state_q == S_RUN);
        done_o       = (state_q == S_DONE);
        inst_pc_o    = pc_q;
        fire         = inst_valid_o && inst_ready_i;

        // Inner-first chain: the first active loop ending here with
        // iterations left takes the jump; exhausted loops ending here rewind
        // their counter and defer to the next outer loop. A loop whose end
        // is elsewhere is not involved and is passed over.
        for (int k = 0; k < 3; k++) begin
            lim = (count_q[k] == '0) ? '0 : count_q[k] - 1'b1;
            if (!redirect && (k < int'(mode_q)) && (pc_q == end_q[k])) begin
                if (cnt_q[k] < lim) begin
                    cnt_nxt[k] = cnt_q[k] + 1'b1;
                    pc_nxt     = jump_q[k];
                    redirect   = 1'b1;
                end else begin
                    cnt_nxt[k] = '0;
                end
            end
        end

        last_end = (mode_q == 2'd0) ? end_q[0] : end_q[mode_q - 2'd1];
        final_pc = !redirect && (pc_q == last_end);

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                    mode_d  = cfg_loop_mode_i;
                    jump_d  = cfg_jump_addr_i;
                    end_d   = cfg_end_addr_i;
                    count_d = cfg_loop_count_i;
                end
            end
            S_RUN: begin
                if (fire) begin
                    if (final_pc) begin
                        state_d = S_DONE;
                        pc_d    = '0;
                        cnt_d   = '0;
                    end else begin
                        pc_d  = pc_nxt;
                        cnt_d = cnt_nxt;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (clr_i) begin
            state_d = S_IDLE;
            pc_d    = '0;
            cnt_d   = '0;
        end
    end

`ifdef INST_LOOP_SEQ_STEP_EN
    always_comb begin
        tok_d = (tok_q && !fire) || dbg_step_i;
        if (clr_i) tok_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tok_q <= 1'b0;
        else       tok_q <= tok_d;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            jump_q  <= '0;
            end_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            jump_q  <= jump_d;
            end_q   <= end_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_inst_loop_sequencer.sv
module tb_inst_loop_sequencer;
    localparam int AW = 8;
    localparam int CW = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start, clr, ready;
    logic [1:0]         mode_i;
    logic [2:0][AW-1:0] jump_i, end_i;
    logic [2:0][CW-1:0] cnt_i;
    logic [AW-1:0]      pc;
    logic               valid, busy, done;
`ifdef INST_LOOP_SEQ_STEP_EN
    logic               step_mode, step;
`endif

    inst_loop_sequencer #(.InstAddrWidth(AW), .LoopCountWidth(CW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .clr_i            (clr),
        .cfg_loop_mode_i  (mode_i),
        .cfg_jump_addr_i  (jump_i),
        .cfg_end_addr_i   (end_i),
        .cfg_loop_count_i (cnt_i),
`ifdef INST_LOOP_SEQ_STEP_EN
        .dbg_step_mode_i  (step_mode),
        .dbg_step_i       (step),
`endif
        .inst_pc_o        (pc),
        .inst_valid_o     (valid),
        .inst_ready_i     (ready),
        .busy_o           (busy),
        .done_o           (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int mj[3], me[3], mc[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: expand the loop nest into the PC trace it should produce.
    // Loop k's body [jump,end] is replayed max(count,1) times, with loop k-1
    // expanded inside each pass.
    function automatic void emit(int lo, int hi);
        for (int p = lo; p <= hi; p++) exp_q.push_back(p);
    endfunction
    function automatic int reps(int k);
        return (mc[k] == 0) ? 1 : mc[k];
    endfunction
    function automatic void g1(int lo, int hi);
        emit(lo, mj[0] - 1);
        for (int r = 0; r < reps(0); r++) emit(mj[0], me[0]);
        emit(me[0] + 1, hi);
    endfunction
    function automatic void g2(int lo, int hi);
        emit(lo, mj[1] - 1);
        for (int r = 0; r < reps(1); r++) g1(mj[1], me[1]);
        emit(me[1] + 1, hi);
    endfunction
    function automatic void g3(int lo, int hi);
        emit(lo, mj[2] - 1);
        for (int r = 0; r < reps(2); r++) g2(mj[2], me[2]);
        emit(me[2] + 1, hi);
    endfunction
    function automatic void build_model(int mode);
        exp_q.delete();
        case (mode)
            0: emit(0, me[0]);
            1: g1(0, me[0]);
            2: g2(0, me[1]);
            default: g3(0, me[2]);
        endcase
    endfunction

    task automatic set_cfg(input int j0, e0, c0, j1, e1, c1, j2, e2, c2);
        mj[0] = j0; me[0] = e0; mc[0] = c0;
        mj[1] = j1; me[1] = e1; mc[1] = c1;
        mj[2] = j2; me[2] = e2; mc[2] = c2;
    endtask

    task automatic drive_cfg(input int mode);
        mode_i = 2'(mode);
        for (int k = 0; k < 3; k++) begin
            jump_i[k] = AW'(mj[k]);
            end_i[k]  = AW'(me[k]);
            cnt_i[k]  = CW'(mc[k]);
        end
    endtask

    // rdy_mode: 0 always ready, 1 toggling, 2 random. noise scrambles the
    // CSR inputs and pulses start during the run; none of it may matter.
    task automatic run_seq(input int mode, input int rdy_mode, input bit noise);
        int cyc = 0;
        bit stalled = 0;
        logic [AW-1:0] prev_pc = '0;
        build_model(mode);
        @(negedge clk);
        drive_cfg(mode);
        start = 1;
        @(negedge clk);
        start = 0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            case (rdy_mode)
                0:       ready = 1;
                1:       ready = (cyc % 2 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (noise) begin
                mode_i = 2'($urandom_range(0, 3));
                jump_i = 24'($urandom);
                end_i  = 24'($urandom);
                cnt_i  = 24'($urandom);
                start  = ($urandom_range(0, 3) == 0);
            end
            chk("busy_run", busy, 1);
            chk("valid_run", valid, 1);
            if (stalled) chk("pc_hold", pc, prev_pc);
            if (valid && ready) chk("pc", pc, exp_q.pop_front());
            stalled = valid && !ready;
            prev_pc = pc;
            cyc++;
            @(negedge clk);
        end
        start = 0;
        if (exp_q.size() != 0) chk("timeout", exp_q.size(), 0);
        chk("done_pulse", done, 1);
        chk("valid_done", valid, 0);
        chk("busy_done", busy, 0);
        chk("pc_done", pc, 0);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic rand_cfg(output int mode);
        mode = $urandom_range(0, 3);
        for (int k = 0; k < 3; k++) begin
            mj[k] = $urandom_range(0, 255);
            me[k] = $urandom_range(0, 255);
            mc[k] = $urandom_range(0, 255);
        end
        if (mode == 0) begin
            me[0] = $urandom_range(0, 12);
        end else begin
            mj[0] = $urandom_range(0, 8);
            me[0] = mj[0] + $urandom_range(0, 4);
            mc[0] = $urandom_range(0, 3);
            for (int k = 1; k < mode; k++) begin
                mj[k] = $urandom_range(0, mj[k-1]);
                me[k] = me[k-1] + $urandom_range(0, 3);
                mc[k] = $urandom_range(0, 3);
            end
        end
    endtask

    initial begin
        int mode, rm, fires;
        rst = 1; start = 0; clr = 0; ready = 0;
        mode_i = '0; jump_i = '0; end_i = '0; cnt_i = '0;
`ifdef INST_LOOP_SEQ_STEP_EN
        step_mode = 0; step = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_done", done, 0);
        chk("rst_busy_after", busy, 0);

        set_cfg(0, 5, 0, 0, 0, 0, 0, 0, 0);       run_seq(0, 0, 0);
        set_cfg(2, 4, 3, 0, 0, 0, 0, 0, 0);       run_seq(1, 0, 0);
        set_cfg(1, 2, 2, 0, 3, 2, 0, 0, 0);       run_seq(2, 0, 0);
        set_cfg(2, 3, 2, 0, 3, 2, 0, 0, 0);       run_seq(2, 1, 0);
        set_cfg(2, 4, 0, 0, 0, 0, 0, 0, 0);       run_seq(1, 0, 0);

        // Clear at the 4th fire of the single-loop program
        set_cfg(2, 4, 3, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive_cfg(1);
        start = 1;
        @(negedge clk);
        start = 0;
        ready = 1;
        fires = 0;
        for (int c = 0; c < 20 && fires < 4; c++) begin
            if (valid && ready) begin
                fires++;
                if (fires == 4) clr = 1;
            end
            @(negedge clk);
        end
        clr = 0;
        chk("clr_fires", fires, 4);
        chk("clr_valid", valid, 0);
        chk("clr_pc", pc, 0);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        @(negedge clk);
        chk("clr_no_done", done, 0);

        // Asynchronous reset mid-run aborts without a done pulse
        @(negedge clk);
        drive_cfg(1);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        #1 rst = 1;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_pc", pc, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("arst_no_done", done, 0);
        @(negedge clk);
        chk("arst_idle", busy, 0);

        for (int i = 0; i < 25; i++) begin
            rand_cfg(mode);
            rm = $urandom_range(0, 2);
            run_seq(mode, rm, 1);
        end

`ifdef INST_LOOP_SEQ_STEP_EN
        set_cfg(0, 10, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive_cfg(0);
        step_mode = 1;
        ready = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        fires = 0;
        for (int c = 0; c < 40; c++) begin
            step = (c == 3 || c == 10 || c == 20);
            if (valid && ready) begin
                chk("step_pc", pc, fires);
                fires++;
            end
            @(negedge clk);
        end
        step = 0;
        chk("step_fires", fires, 3);
        clr = 1;
        @(negedge clk);
        clr = 0;
        step_mode = 0;
        chk("step_clr_busy", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
